// File: rtl/se_sram_pkg.sv
// Shared definitions for the se_sram family: lane arithmetic, latency codes and the
// elaboration-time parameter guard used by every array top.
`ifndef SE_SRAM_PKG_SV
`define SE_SRAM_PKG_SV

// Expands to a generate block that stops elaboration on an unusable configuration.
`define SE_SRAM_CHECK_PARAMS(dw, bw, lat) \
  if ((((dw) % (bw)) != 0) || (((lat) != SE_SRAM_LAT1) && ((lat) != SE_SRAM_LAT2))) \
  begin : g_bad_params \
    $error("se_sram: data_width must be a multiple of byte_width, read_latency 1 or 2"); \
  end

package se_sram_pkg;

  localparam int unsigned SE_SRAM_LAT1 = 1;
  localparam int unsigned SE_SRAM_LAT2 = 2;

  function automatic int unsigned lane_count(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

endpackage

`endif

// File: rtl/se_sram_read_pipe.sv
// Per-port read output stage: one or two enabled register stages with a matching valid
// strobe. Everything freezes while the clock enable is low.
module se_sram_read_pipe
  import se_sram_pkg::*;
#(
  parameter int unsigned data_width   = 32,
  parameter int unsigned read_latency = SE_SRAM_LAT1
) (
  input  logic                  sram_clock,
  input  logic                  sram_reset,
  input  logic                  sram_clock__enable,
  input  logic                  read_request,
  input  logic [data_width-1:0] read_word,
  output logic [data_width-1:0] data_out,
  output logic                  data_out_valid
);

  logic [data_width-1:0] data_q;
  logic                  valid_q;

  if (read_latency == SE_SRAM_LAT2) begin : g_lat2
    logic [data_width-1:0] stage_q;
    logic                  stage_valid_q;

    always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
        stage_q       <= '0;
        stage_valid_q <= 1'b0;
        data_q        <= '0;
        valid_q       <= 1'b0;
      end else if (sram_clock__enable) begin
        stage_valid_q <= read_request;
        if (read_request) stage_q <= read_word;
        valid_q <= stage_valid_q;
        if (stage_valid_q) data_q <= stage_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (sram_clock__enable) begin
        valid_q <= read_request;
        if (read_request) data_q <= read_word;
      end
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;

endmodule

// File: rtl/se_sram_mrw_2p.sv
// Two-port synchronous SRAM with byte-lane writes, A-priority write merge, write-through
// forwarding on same-address read/write, and selectable read latency.
module se_sram_mrw_2p
  import se_sram_pkg::*;
#(
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 32,
  parameter int unsigned byte_width    = 8,
  parameter int unsigned read_latency  = SE_SRAM_LAT1,
  parameter string       initfile      = ""
) (
  input  logic                             sram_clock,
  input  logic                             sram_reset,
  input  logic                             sram_clock__enable,
  input  logic                             select_a,
  input  logic                             read_not_write_a,
  input  logic [data_width/byte_width-1:0] write_enable_a,
  input  logic [address_width-1:0]         address_a,
  input  logic [data_width-1:0]            write_data_a,
  output logic [data_width-1:0]            data_out_a,
  output logic                             data_out_valid_a,
  input  logic                             select_b,
  input  logic                             read_not_write_b,
  input  logic [data_width/byte_width-1:0] write_enable_b,
  input  logic [address_width-1:0]         address_b,
  input  logic [data_width-1:0]            write_data_b,
  output logic [data_width-1:0]            data_out_b,
  output logic                             data_out_valid_b,
  output logic                             write_collision
);

  `SE_SRAM_CHECK_PARAMS(data_width, byte_width, read_latency)

  localparam int unsigned lanes = lane_count(data_width, byte_width);
  localparam int unsigned depth = 1 << address_width;

  (* ram_init_file = initfile *) logic [data_width-1:0] mem [depth];

  // Lanes enabled by A take A's data, else lanes enabled by B take B's, else old contents.
  function automatic logic [data_width-1:0] lane_merge(
    input logic [data_width-1:0] old_word,
    input logic [lanes-1:0]      en_a,
    input logic [data_width-1:0] data_a,
    input logic [lanes-1:0]      en_b,
    input logic [data_width-1:0] data_b
  );
    logic [data_width-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < lanes; i++) begin
      if (en_a[i]) begin
        merged[i*byte_width +: byte_width] = data_a[i*byte_width +: byte_width];
      end else if (en_b[i]) begin
        merged[i*byte_width +: byte_width] = data_b[i*byte_width +: byte_width];
      end
    end
    return merged;
  endfunction

  logic             rd_a, rd_b, wr_a, wr_b, same_addr;
  logic [lanes-1:0] we_a_eff, we_b_eff;
  logic [data_width-1:0] word_a, word_b;
  logic             collision_q;

  always_comb begin
    rd_a      = select_a & read_not_write_a;
    rd_b      = select_b & read_not_write_b;
    wr_a      = select_a & ~read_not_write_a & (|write_enable_a);
    wr_b      = select_b & ~read_not_write_b & (|write_enable_b);
    same_addr = (address_a == address_b);
    we_a_eff  = wr_a ? write_enable_a : '0;
    we_b_eff  = wr_b ? write_enable_b : '0;
    // Each port's view of its address after this edge's writes: the value written back
    // when it writes, and the forwarded word when it reads.
    word_a = lane_merge(mem[address_a], we_a_eff, write_data_a,
                        same_addr ? we_b_eff : '0, write_data_b);
    word_b = lane_merge(mem[address_b], same_addr ? we_a_eff : '0, write_data_a,
                        we_b_eff, write_data_b);
  end

  always_ff @(posedge sram_clock) begin
    if (!sram_reset && sram_clock__enable) begin
      if (wr_a) mem[address_a] <= word_a;
      if (wr_b) mem[address_b] <= word_b;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      collision_q <= 1'b0;
    end else if (sram_clock__enable) begin
      collision_q <= wr_a & wr_b & same_addr & (|(write_enable_a & write_enable_b));
    end
  end

  assign write_collision = collision_q;

  se_sram_read_pipe #(
    .data_width  (data_width),
    .read_latency(read_latency)
  ) u_pipe_a (
    .sram_clock        (sram_clock),
    .sram_reset        (sram_reset),
    .sram_clock__enable(sram_clock__enable),
    .read_request      (rd_a),
    .read_word         (word_a),
    .data_out          (data_out_a),
    .data_out_valid    (data_out_valid_a)
  );

  se_sram_read_pipe #(
    .data_width  (data_width),
    .read_latency(read_latency)
  ) u_pipe_b (
    .sram_clock        (sram_clock),
    .sram_reset        (sram_reset),
    .sram_clock__enable(sram_clock__enable),
    .read_request      (rd_b),
    .read_word         (word_b),
    .data_out          (data_out_b),
    .data_out_valid    (data_out_valid_b)
  );

endmodule

// File: tb/tb_se_sram_mrw_2p.sv
// Scoreboard bench: a latency-1 and a latency-2 instance share one stimulus stream and are
// checked against a word-array reference model with queued timed read responses.
module tb_se_sram_mrw_2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs (shared by both instances)
  logic        rst = 1'b1, en = 1'b1;
  logic        sel_a = 1'b0, rnw_a = 1'b0, sel_b = 1'b0, rnw_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0, addr_a = '0, addr_b = '0;
  logic [31:0] wd_a = '0, wd_b = '0;

  // staged stimulus for the next edge
  logic        s_rst, s_en, s_sel_a, s_rnw_a, s_sel_b, s_rnw_b;
  logic [3:0]  s_we_a, s_we_b, s_addr_a, s_addr_b;
  logic [31:0] s_wd_a, s_wd_b;

  // index: 0 = A lat1, 1 = B lat1, 2 = A lat2, 3 = B lat2
  logic [31:0] dout [4];
  logic        vld [4];
  logic        coll1, coll2;

  se_sram_mrw_2p #(
    .address_width(4), .data_width(32), .byte_width(8), .read_latency(1), .initfile("")
  ) u_dut1 (
    .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en),
    .select_a(sel_a), .read_not_write_a(rnw_a), .write_enable_a(we_a),
    .address_a(addr_a), .write_data_a(wd_a), .data_out_a(dout[0]), .data_out_valid_a(vld[0]),
    .select_b(sel_b), .read_not_write_b(rnw_b), .write_enable_b(we_b),
    .address_b(addr_b), .write_data_b(wd_b), .data_out_b(dout[1]), .data_out_valid_b(vld[1]),
    .write_collision(coll1)
  );

  se_sram_mrw_2p #(
    .address_width(4), .data_width(32), .byte_width(8), .read_latency(2), .initfile("")
  ) u_dut2 (
    .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en),
    .select_a(sel_a), .read_not_write_a(rnw_a), .write_enable_a(we_a),
    .address_a(addr_a), .write_data_a(wd_a), .data_out_a(dout[2]), .data_out_valid_a(vld[2]),
    .select_b(sel_b), .read_not_write_b(rnw_b), .write_enable_b(we_b),
    .address_b(addr_b), .write_data_b(wd_b), .data_out_b(dout[3]), .data_out_valid_b(vld[3]),
    .write_collision(coll2)
  );

  // reference model
  logic [31:0] mem_m [16];
  logic [63:0] sb [4][$];       // {due enabled-edge number, expected word}
  int unsigned ecount = 0;      // enabled, non-reset edges seen so far
  logic        coll_next = 1'b0;
  logic        exp_coll = 1'b0;
  logic [31:0] last_d [4];
  logic        last_v [4];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (port %0d) @%0t: got %h, expected %h", nm, p, $time, act, exp);
    end
  endtask

  task automatic idle();
    s_rst = 1'b0; s_en = 1'b1;
    s_sel_a = 1'b0; s_rnw_a = 1'b0; s_we_a = '0; s_addr_a = '0; s_wd_a = '0;
    s_sel_b = 1'b0; s_rnw_b = 1'b0; s_we_b = '0; s_addr_b = '0; s_wd_b = '0;
  endtask

  task automatic wr_port_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
    s_sel_a = 1'b1; s_rnw_a = 1'b0; s_addr_a = a; s_wd_a = d; s_we_a = w;
  endtask
  task automatic wr_port_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
    s_sel_b = 1'b1; s_rnw_b = 1'b0; s_addr_b = a; s_wd_b = d; s_we_b = w;
  endtask
  task automatic rd_port_a(input logic [3:0] a);
    s_sel_a = 1'b1; s_rnw_a = 1'b1; s_addr_a = a;
  endtask
  task automatic rd_port_b(input logic [3:0] a);
    s_sel_b = 1'b1; s_rnw_b = 1'b1; s_addr_b = a;
  endtask

  // Apply staged stimulus for the coming edge and advance the model to match.
  task automatic step();
    bit rda, rdb, wra, wrb;
    int unsigned e0;
    @(negedge clk);
    rst = s_rst; en = s_en;
    sel_a = s_sel_a; rnw_a = s_rnw_a; we_a = s_we_a; addr_a = s_addr_a; wd_a = s_wd_a;
    sel_b = s_sel_b; rnw_b = s_rnw_b; we_b = s_we_b; addr_b = s_addr_b; wd_b = s_wd_b;
    rda = s_sel_a && s_rnw_a;
    rdb = s_sel_b && s_rnw_b;
    wra = s_sel_a && !s_rnw_a && (s_we_a != 0);
    wrb = s_sel_b && !s_rnw_b && (s_we_b != 0);
    if (s_rst) begin
      for (int p = 0; p < 4; p++) sb[p].delete();
      coll_next = 1'b0;
    end else if (s_en) begin
      // B first, then A on top: A wins shared lanes at a shared address
      for (int i = 0; i < 4; i++) if (wrb && s_we_b[i]) mem_m[s_addr_b][i*8 +: 8] = s_wd_b[i*8 +: 8];
      for (int i = 0; i < 4; i++) if (wra && s_we_a[i]) mem_m[s_addr_a][i*8 +: 8] = s_wd_a[i*8 +: 8];
      coll_next = wra && wrb && (s_addr_a == s_addr_b) && ((s_we_a & s_we_b) != 0);
      e0 = ecount + 1;
      if (rda) begin
        sb[0].push_back({e0, mem_m[s_addr_a]});
        sb[2].push_back({e0 + 1, mem_m[s_addr_a]});
      end
      if (rdb) begin
        sb[1].push_back({e0, mem_m[s_addr_b]});
        sb[3].push_back({e0 + 1, mem_m[s_addr_b]});
      end
    end
  endtask

  // monitor
  initial begin
    logic en_s, rs_s, ev;
    for (int p = 0; p < 4; p++) begin last_d[p] = '0; last_v[p] = 1'b0; end
    forever begin
      @(posedge clk);
      en_s = en; rs_s = rst;
      #1;
      if (rs_s) begin
        exp_coll = 1'b0;
        for (int p = 0; p < 4; p++) begin last_d[p] = '0; last_v[p] = 1'b0; end
      end else if (en_s) begin
        ecount++;
        exp_coll = coll_next;
        for (int p = 0; p < 4; p++) begin
          ev = 1'b0;
          if (sb[p].size() > 0 && sb[p][0][63:32] < ecount) begin
            check("missed_read", p, 32'(sb[p].size()), 32'd0);
            void'(sb[p].pop_front());
          end
          if (sb[p].size() > 0 && sb[p][0][63:32] == ecount) begin
            ev = 1'b1;
            last_d[p] = sb[p][0][31:0];
            void'(sb[p].pop_front());
          end
          last_v[p] = ev;
        end
      end
      for (int p = 0; p < 4; p++) begin
        check("data_out_valid", p, {31'd0, vld[p]}, {31'd0, last_v[p]});
        check("data_out", p, dout[p], last_d[p]);
      end
      check("write_collision", 1, {31'd0, coll1}, {31'd0, exp_coll});
      check("write_collision", 2, {31'd0, coll2}, {31'd0, exp_coll});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    idle(); s_rst = 1'b1;
    repeat (3) step();
    // known array contents
    for (int i = 0; i < 16; i++) begin idle(); wr_port_a(4'(i), 32'd0, 4'hF); step(); end

    // full-word write then read
    idle(); wr_port_a(4'd3, 32'hDEADBEEF, 4'hF); step();
    idle(); rd_port_a(4'd3); step();
    // byte-lane write from B
    idle(); wr_port_b(4'd3, 32'h11223344, 4'b0101); step();
    idle(); rd_port_b(4'd3); step();
    // W/W collision
    idle(); wr_port_a(4'd5, 32'hAAAAAAAA, 4'b0011); wr_port_b(4'd5, 32'hBBBBBBBB, 4'b0110); step();
    idle(); rd_port_a(4'd5); step();
    // R/W same address: forwarding
    idle(); rd_port_a(4'd7); wr_port_b(4'd7, 32'h12345678, 4'hF); step();
    idle(); step(); step();
    // enable gating with a write attempted while frozen
    idle(); rd_port_a(4'd3); step();
    idle(); s_en = 1'b0; wr_port_b(4'd3, 32'hFFFFFFFF, 4'hF); rd_port_a(4'd9);
    repeat (3) step();
    idle(); step();
    idle(); rd_port_b(4'd3); step();
    // reset one cycle after a read; write during reset is ignored
    idle(); rd_port_a(4'd5); step();
    idle(); s_rst = 1'b1; wr_port_a(4'd5, 32'h55555555, 4'hF); step();
    idle(); s_rst = 1'b1; step();
    idle(); rd_port_a(4'd5); step();
    idle(); step(); step();

    // randomized traffic
    for (int n = 0; n < 700; n++) begin
      idle();
      s_en    = ($urandom_range(0, 4) != 0);
      s_rst   = ($urandom_range(0, 49) == 0);
      s_sel_a = 1'($urandom); s_rnw_a = 1'($urandom); s_we_a = 4'($urandom);
      s_addr_a = 4'($urandom_range(0, 5)); s_wd_a = $urandom;
      s_sel_b = 1'($urandom); s_rnw_b = 1'($urandom); s_we_b = 4'($urandom);
      s_addr_b = 4'($urandom_range(0, 5)); s_wd_b = $urandom;
      step();
    end
    idle();
    repeat (4) step();
    @(posedge clk); #2;
    for (int p = 0; p < 4; p++) check("sb_drained", p, 32'(sb[p].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
